pc_sequencer: RTL and testbench

//  Fetch/execute sequencer for program_counter: runs the fetch FSM, handshakes with instruction memory and the execute stage,
//  and drives the PC control inputs (increment, In, ImmIn, WriteEnable). program_counter clears to 0 when neither increment
//  nor WriteEnable is set, so this block holds PC explicitly with increment=1, In=8'h00. Sits between decoder/datapath and PC.

---
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between pc_sequencer and its neighbours: run control, instruction
// memory, execute stage and program_counter control.
//
// Handshakes: MemReq (valid) and MemAck (ready) form the fetch handshake. The word on
// MemData transfers in the cycle both are high, and MemReq then drops. InstrValid
// (valid) and ExecDone (ready) form the execute handshake. The decode flags are
// consumed in the cycle both are high. A ready seen without its valid is ignored.
interface pc_sequencer_if;
  logic        Run;
  logic        MemAck;
  logic [15:0] MemData;
  logic        ExecDone;
  logic        IsHalt;
  logic        IsJump;
  logic        IsBranch;
  logic        BranchCond;
  logic [7:0]  BranchDisp;
  logic [15:0] JumpTarget;

  logic        PcIncrement;
  logic [7:0]  PcIn;
  logic [15:0] PcImm;
  logic        PcWriteEnable;
  logic        MemReq;
  logic        InstrValid;
  logic [15:0] InstrOut;
  logic        Halted;
  logic        Fault;
  logic [15:0] RetiredCount;

  modport master (
    input  Run, MemAck, MemData, ExecDone, IsHalt, IsJump, IsBranch, BranchCond,
           BranchDisp, JumpTarget,
    output PcIncrement, PcIn, PcImm, PcWriteEnable, MemReq, InstrValid, InstrOut,
           Halted, Fault, RetiredCount
  );

  modport slave (
    output Run, MemAck, MemData, ExecDone, IsHalt, IsJump, IsBranch, BranchCond,
           BranchDisp, JumpTarget,
    input  PcIncrement, PcIn, PcImm, PcWriteEnable, MemReq, InstrValid, InstrOut,
           Halted, Fault, RetiredCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving program_counter's control inputs. program_counter
// clears itself when it is left idle, so every hold state keeps increment=1 with In=0.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR  = 16'h0000,
  parameter logic [7:0]  STEP          = 8'd1,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  pc_sequencer_if.master bus,
  output logic [2:0]    DebugState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    D_STEP   = 2'd0,
    D_BRANCH = 2'd1,
    D_JUMP   = 2'd2
  } dec_t;

  localparam logic [15:0] TMO_LAST = (FETCH_TIMEOUT > 0) ? 16'(FETCH_TIMEOUT - 1) : 16'd0;

  state_t      state;
  state_t      next_state;
  dec_t        dec_kind;
  logic [7:0]  dec_disp;
  logic [15:0] dec_target;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        fetch_done;
  logic        exec_done;

  assign fetch_done = (state == S_FETCH) && bus.MemAck;
  assign exec_done  = (state == S_EXEC) && bus.ExecDone;
  assign tmo_hit    = (FETCH_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign DebugState = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (bus.Run) next_state = S_START;
      S_START:  next_state = S_FETCH;
      // An acknowledge in the last allowed cycle still beats the timeout.
      S_FETCH: begin
        if (bus.MemAck)   next_state = S_EXEC;
        else if (tmo_hit) next_state = S_FAULT;
      end
      S_EXEC: begin
        if (bus.ExecDone) next_state = bus.IsHalt ? S_HALT : S_UPDATE;
      end
      S_UPDATE: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PcIncrement   = 1'b1;
    bus.PcIn          = 8'h00;
    bus.PcImm         = 16'h0000;
    bus.PcWriteEnable = 1'b0;
    bus.MemReq        = 1'b0;
    bus.InstrValid    = 1'b0;
    bus.Halted        = 1'b0;
    bus.Fault         = 1'b0;
    case (state)
      S_START: begin
        bus.PcWriteEnable = 1'b1;
        bus.PcImm         = RESET_VECTOR;
        bus.PcIncrement   = 1'b0;
      end
      S_FETCH: bus.MemReq     = 1'b1;
      S_EXEC:  bus.InstrValid = 1'b1;
      S_UPDATE: begin
        case (dec_kind)
          D_JUMP: begin
            bus.PcWriteEnable = 1'b1;
            bus.PcImm         = dec_target;
            bus.PcIncrement   = 1'b0;
          end
          D_BRANCH: bus.PcIn = dec_disp;
          default:  bus.PcIn = STEP;
        endcase
      end
      S_HALT:  bus.Halted = 1'b1;
      S_FAULT: bus.Fault  = 1'b1;
      default: ;
    endcase
  end

  // Counter sits at zero outside FETCH, so every FETCH visit starts counting from zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                 tmo_cnt <= 16'h0000;
    else if (state != S_FETCH) tmo_cnt <= 16'h0000;
    else                       tmo_cnt <= tmo_cnt + 16'h0001;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.InstrOut     <= 16'h0000;
      bus.RetiredCount <= 16'h0000;
      dec_kind         <= D_STEP;
      dec_disp         <= 8'h00;
      dec_target       <= 16'h0000;
    end else begin
      if (fetch_done) bus.InstrOut <= bus.MemData;
      if (exec_done) begin
        bus.RetiredCount <= bus.RetiredCount + 16'h0001;
        dec_disp         <= bus.BranchDisp;
        dec_target       <= bus.JumpTarget;
        if (bus.IsHalt)                          dec_kind <= D_STEP;
        else if (bus.IsJump)                     dec_kind <= D_JUMP;
        else if (bus.IsBranch && bus.BranchCond) dec_kind <= D_BRANCH;
        else                                     dec_kind <= D_STEP;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a program_counter model follows the block's control outputs,
// and every fetch address is compared with the address implied by the instruction stream.
module tb_pc_sequencer;
  localparam logic [15:0] RV  = 16'h0040;
  localparam int          TMO = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  DebugState;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(RV), .STEP(8'd1), .FETCH_TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus), .DebugState(DebugState)
  );

  always #5 Clock = ~Clock;

  // program_counter: write wins, else add In, else clear
  logic [15:0] env_pc;
  always @(posedge Clock) begin
    if (bus.PcWriteEnable)    env_pc <= bus.PcImm;
    else if (bus.PcIncrement) env_pc <= env_pc + {8'h00, bus.PcIn};
    else                      env_pc <= 16'h0000;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;
  logic [15:0] exp_retired;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Run = 1'b0; bus.MemAck = 1'b0; bus.MemData = 16'h0000; bus.ExecDone = 1'b0;
    bus.IsHalt = 1'b0; bus.IsJump = 1'b0; bus.IsBranch = 1'b0; bus.BranchCond = 1'b0;
    bus.BranchDisp = 8'h00; bus.JumpTarget = 16'h0000;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inc"},     16'(bus.PcIncrement),   16'd1);
    check({tag, "_in"},      16'(bus.PcIn),          16'd0);
    check({tag, "_imm"},     bus.PcImm,              16'd0);
    check({tag, "_we"},      16'(bus.PcWriteEnable), 16'd0);
    check({tag, "_memreq"},  16'(bus.MemReq),        16'd0);
    check({tag, "_ivalid"},  16'(bus.InstrValid),    16'd0);
    check({tag, "_instr"},   bus.InstrOut,           16'd0);
    check({tag, "_halted"},  16'(bus.Halted),        16'd0);
    check({tag, "_fault"},   16'(bus.Fault),         16'd0);
    check({tag, "_retired"}, bus.RetiredCount,       16'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    Reset = 1'b0;
    exp_retired = 16'd0;
    exp_q.delete();
  endtask

  task automatic start_run();
    bus.Run = 1'b1;
    tick();
    bus.Run = 1'b0;
    check("start_we",  16'(bus.PcWriteEnable), 16'd1);
    check("start_imm", bus.PcImm,              RV);
    check("start_inc", 16'(bus.PcIncrement),   16'd0);
    check("start_req", 16'(bus.MemReq),        16'd0);
    tick();
    exp_pc = RV;
  endtask

  // Caller is in the first FETCH cycle; ack arrives on FETCH cycle delay+1.
  task automatic fetch(input int delay, input logic [15:0] data);
    check("fetch_addr", env_pc, exp_pc);
    for (int i = 0; i < delay; i++) begin
      bus.ExecDone = 1'($urandom_range(0, 1));
      check("fetch_req",   16'(bus.MemReq), 16'd1);
      check("fetch_fault", 16'(bus.Fault),  16'd0);
      tick();
    end
    bus.ExecDone = 1'b0;
    check("fetch_req", 16'(bus.MemReq), 16'd1);
    bus.MemAck  = 1'b1;
    bus.MemData = data;
    exp_q.push_back(data);
    tick();
    bus.MemAck  = 1'b0;
    bus.MemData = 16'($urandom);
    check("exec_ivalid", 16'(bus.InstrValid), 16'd1);
    check("exec_req",    16'(bus.MemReq),     16'd0);
    check("exec_instr",  bus.InstrOut,        exp_q.pop_front());
  endtask

  task automatic execute(input int delay, input logic halt, input logic jump,
                         input logic branch, input logic cond,
                         input logic [7:0] disp, input logic [15:0] target);
    for (int i = 0; i < delay; i++) begin
      bus.MemAck = 1'b1;
      bus.Run    = 1'b1;
      check("exec_wait", 16'(bus.InstrValid), 16'd1);
      tick();
    end
    bus.MemAck = 1'b0; bus.Run = 1'b0;
    bus.ExecDone = 1'b1; bus.IsHalt = halt; bus.IsJump = jump; bus.IsBranch = branch;
    bus.BranchCond = cond; bus.BranchDisp = disp; bus.JumpTarget = target;
    tick();
    bus.ExecDone = 1'b0;
    bus.IsHalt = 1'($urandom); bus.IsJump = 1'($urandom); bus.IsBranch = 1'($urandom);
    bus.BranchDisp = 8'($urandom); bus.JumpTarget = 16'($urandom);
    exp_retired = exp_retired + 16'd1;
    check("retired", bus.RetiredCount, exp_retired);
    if (halt) begin
      for (int i = 0; i < 5; i++) begin
        check("halt_halted", 16'(bus.Halted),        16'd1);
        check("halt_in",     16'(bus.PcIn),          16'd0);
        check("halt_we",     16'(bus.PcWriteEnable), 16'd0);
        check("halt_req",    16'(bus.MemReq),        16'd0);
        check("halt_pc",     env_pc,                 exp_pc);
        bus.Run = 1'b1; bus.MemAck = 1'b1; bus.ExecDone = 1'b1;
        tick();
      end
      clear_inputs();
      check("halt_retired", bus.RetiredCount, exp_retired);
    end else begin
      check("upd_ivalid", 16'(bus.InstrValid), 16'd0);
      if (jump) begin
        check("upd_we",  16'(bus.PcWriteEnable), 16'd1);
        check("upd_imm", bus.PcImm,              target);
        check("upd_inc", 16'(bus.PcIncrement),   16'd0);
        exp_pc = target;
      end else begin
        check("upd_we",  16'(bus.PcWriteEnable), 16'd0);
        check("upd_inc", 16'(bus.PcIncrement),   16'd1);
        if (branch && cond) begin
          check("upd_in_br", 16'(bus.PcIn), 16'(disp));
          exp_pc = exp_pc + 16'(disp);
        end else begin
          check("upd_in_step", 16'(bus.PcIn), 16'd1);
          exp_pc = exp_pc + 16'd1;
        end
      end
      tick();
      check("refetch_req", 16'(bus.MemReq), 16'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    tick();
    check("idle_req", 16'(bus.MemReq), 16'd0);
    start_run();

    fetch(0, 16'hA5A5);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    fetch(1, 16'h1111);
    execute(1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 16'h0000);
    fetch(2, 16'h2222);
    execute(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    fetch(3, 16'h3333);
    execute(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 16'h1234);
    fetch(0, 16'h4444);
    execute(2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, TMO - 1), 16'($urandom));
      execute($urandom_range(0, 2), 1'b0, ($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
    end

    fetch(1, 16'hDEAD);
    execute(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 16'hBEEF);

    // Fetch timeout
    do_reset();
    start_run();
    check("tmo_addr", env_pc, exp_pc);
    for (int i = 0; i < TMO; i++) begin
      check("tmo_fault_early", 16'(bus.Fault),  16'd0);
      check("tmo_req",         16'(bus.MemReq), 16'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("tmo_fault",   16'(bus.Fault),         16'd1);
      check("tmo_req_off", 16'(bus.MemReq),        16'd0);
      check("tmo_in",      16'(bus.PcIn),          16'd0);
      check("tmo_we",      16'(bus.PcWriteEnable), 16'd0);
      check("tmo_pc",      env_pc,                 exp_pc);
      bus.MemAck = 1'b1; bus.Run = 1'b1;
      tick();
    end
    clear_inputs();

    // Asynchronous reset in the middle of EXEC
    do_reset();
    start_run();
    fetch(0, 16'h5A5A);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    fetch(1, 16'h6B6B);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_values("async");
    tick();
    Reset = 1'b0;
    exp_retired = 16'd0;
    exp_q.delete();
    start_run();
    fetch(0, 16'h7C7C);
    execute(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
